// File: rtl/larson_pkg.sv
// larson_pkg: shared sweep state encoding and direction constants for the Larson scanner
package larson_pkg;
    typedef enum logic [1:0] {
        SWEEP_UP   = 2'd0,
        DWELL_TOP  = 2'd1,
        SWEEP_DOWN = 2'd2,
        DWELL_BOT  = 2'd3
    } sweep_state_t;
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/larson_sweep_ctrl_if.sv
// larson_sweep_ctrl_if: run/reverse controls and lamp outputs of the sweep sequencer
interface larson_sweep_ctrl_if #(
    parameter int N_LAMPS = 8
);
    localparam int PW = $clog2(N_LAMPS);
    logic               i_en;
    logic               i_rev;
    logic [N_LAMPS-1:0] o_lamps;
    logic [PW-1:0]      o_pos;
    logic               o_dir;
    logic               o_end;
    modport master (
        output i_en, i_rev,
        input  o_lamps, o_pos, o_dir, o_end
    );
    modport slave (
        input  i_en, i_rev,
        output o_lamps, o_pos, o_dir, o_end
    );
endinterface

// File: rtl/larson_prescaler.sv
// larson_prescaler: divides the clock into one step pulse every DIV enabled cycles
module larson_prescaler #(
    parameter int DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_step
);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        o_step = i_en && cnt_q == LAST;
        cnt_d  = (!i_en || o_step) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/larson_sweep_ctrl.sv
// larson_sweep_ctrl: ping-pong one-lamp sweep with end dwell and reversal requests
// Define LARSON_TRAIL_EN to also light the previously visited lamp.
module larson_sweep_ctrl
    import larson_pkg::*;
#(
    parameter int N_LAMPS = 8,
    parameter int DIV     = 4,
    parameter int DWELL   = 0
) (
    input logic                i_clk,
    input logic                i_rst,
    larson_sweep_ctrl_if.slave bus
);
    localparam int PW = $clog2(N_LAMPS);
    localparam int DW = DWELL > 0 ? $clog2(DWELL + 1) : 1;
    localparam logic [PW-1:0] TOP = PW'(N_LAMPS - 1);
    localparam logic [N_LAMPS-1:0] ONE = N_LAMPS'(1);
    sweep_state_t       state_q, state_d;
    logic [PW-1:0]      pos_q, pos_d, up_pos, dn_pos;
    logic [DW-1:0]      dwell_q, dwell_d;
    logic [N_LAMPS-1:0] lamps_q, lamps_d;
    logic               dir_q, dir_d, rev_q, rev_d, end_q, end_d;
    logic               step, move, at_top, at_bot, rev_req, dwelling;
`ifdef LARSON_TRAIL_EN
    logic [PW-1:0]      prev_q, prev_d;
`endif
    larson_prescaler #(.DIV(DIV)) u_pre (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (bus.i_en),
        .o_step (step)
    );
    // A reversal is honoured only when neither the current nor the normal target position is an end.
    always_comb begin
        up_pos   = pos_q + 1'b1;
        dn_pos   = pos_q - 1'b1;
        at_top   = pos_q == TOP;
        at_bot   = pos_q == '0;
        rev_req  = rev_q | bus.i_rev;
        dwelling = state_q == DWELL_TOP || state_q == DWELL_BOT;
        state_d  = state_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        dwell_d  = dwell_q;
        move     = 1'b0;
        rev_d    = dwelling ? 1'b0 : bus.i_en ? rev_req : rev_q;
        if (step) begin
            rev_d = 1'b0;
            case (state_q)
                SWEEP_UP:
                    if (at_top && DWELL > 0) begin
                        state_d = DWELL_TOP;
                        dwell_d = '0;
                    end else if (at_top || (rev_req && !at_bot && up_pos != TOP)) begin
                        state_d = SWEEP_DOWN;
                        dir_d   = DIR_DOWN;
                        pos_d   = dn_pos;
                        move    = 1'b1;
                    end else begin
                        pos_d = up_pos;
                        move  = 1'b1;
                    end
                DWELL_TOP:
                    if (int'(dwell_q) == DWELL - 1) begin
                        state_d = SWEEP_DOWN;
                        dir_d   = DIR_DOWN;
                        pos_d   = dn_pos;
                        move    = 1'b1;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                SWEEP_DOWN:
                    if (at_bot && DWELL > 0) begin
                        state_d = DWELL_BOT;
                        dwell_d = '0;
                    end else if (at_bot || (rev_req && !at_top && dn_pos != '0)) begin
                        state_d = SWEEP_UP;
                        dir_d   = DIR_UP;
                        pos_d   = up_pos;
                        move    = 1'b1;
                    end else begin
                        pos_d = dn_pos;
                        move  = 1'b1;
                    end
                DWELL_BOT:
                    if (int'(dwell_q) == DWELL - 1) begin
                        state_d = SWEEP_UP;
                        dir_d   = DIR_UP;
                        pos_d   = up_pos;
                        move    = 1'b1;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                default: state_d = SWEEP_UP;
            endcase
        end
        end_d = move && (pos_d == '0 || pos_d == TOP);
`ifdef LARSON_TRAIL_EN
        prev_d  = move ? pos_q : prev_q;
        lamps_d = (ONE << pos_d) | (prev_d != pos_d ? ONE << prev_d : '0);
`else
        lamps_d = ONE << pos_d;
`endif
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= SWEEP_UP;
            pos_q   <= '0;
            dir_q   <= DIR_UP;
            dwell_q <= '0;
            rev_q   <= 1'b0;
            end_q   <= 1'b0;
            lamps_q <= ONE;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            dwell_q <= dwell_d;
            rev_q   <= rev_d;
            end_q   <= end_d;
            lamps_q <= lamps_d;
        end
    end
`ifdef LARSON_TRAIL_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) prev_q <= '0;
        else       prev_q <= prev_d;
    end
`endif
    assign bus.o_pos   = pos_q;
    assign bus.o_dir   = dir_q;
    assign bus.o_end   = end_q;
    assign bus.o_lamps = lamps_q;
endmodule

// File: tb/tb_larson_sweep_ctrl.sv
// tb_larson_sweep_ctrl: two sweep configurations checked against a step-level model plus literal sequences
module tb_larson_sweep_ctrl;
    localparam int N  = 4;
    localparam int NC = 2;
`ifdef LARSON_TRAIL_EN
    localparam int TRAIL = 1;
`else
    localparam int TRAIL = 0;
`endif
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, rev = 1'b0;
    int checks = 0, fails = 0;
    bit started = 1'b0;
    int m_pos[NC], m_dir[NC], m_phase[NC], m_here[NC], m_revp[NC], m_prev[NC], m_end[NC];
    int exp_pos0[16] = '{0,0,1,1,2,2,3,3,2,2,1,1,0,0,1,1};
    int exp_dir0[16] = '{1,1,1,1,1,1,1,1,0,0,0,0,0,0,1,1};
    int exp_end0[16] = '{0,0,0,0,0,0,1,0,0,0,0,0,1,0,0,0};
    int exp_pos1[12] = '{0,1,2,3,3,3,2,1,0,0,0,1};
    always #5 clk = ~clk;
    larson_sweep_ctrl_if #(.N_LAMPS(N)) b0 ();
    larson_sweep_ctrl_if #(.N_LAMPS(N)) b1 ();
    assign b0.i_en  = en;
    assign b0.i_rev = rev;
    assign b1.i_en  = en;
    assign b1.i_rev = rev;
    larson_sweep_ctrl #(.N_LAMPS(N), .DIV(2), .DWELL(0)) u0 (.i_clk(clk), .i_rst(rst), .bus(b0));
    larson_sweep_ctrl #(.N_LAMPS(N), .DIV(1), .DWELL(2)) u1 (.i_clk(clk), .i_rst(rst), .bus(b1));
    function automatic int div_of(int k);
        return k == 0 ? 2 : 1;
    endfunction
    function automatic int dwell_of(int k);
        return k == 0 ? 0 : 2;
    endfunction
    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask
    // Step-level model: a lamp moves each step, lingers DWELL extra steps at the far end, then turns.
    task automatic model_tick(int k);
        int tgt;
        bit far, flip;
        if (rst) begin
            m_pos[k] = 0; m_dir[k] = 1; m_phase[k] = 0; m_here[k] = 0;
            m_revp[k] = 0; m_prev[k] = 0; m_end[k] = 0;
            return;
        end
        m_end[k] = 0;
        if (!en) begin
            m_phase[k] = 0;
            return;
        end
        far = m_dir[k] == 1 ? m_pos[k] == N - 1 : m_pos[k] == 0;
        if (m_phase[k] != div_of(k) - 1) begin
            m_phase[k]++;
            m_revp[k] = (far && m_here[k] > 0) ? 0 : (m_revp[k] | int'(rev));
            return;
        end
        m_phase[k] = 0;
        tgt = m_dir[k] == 1 ? m_pos[k] + 1 : m_pos[k] - 1;
        if (far && m_here[k] < dwell_of(k)) begin
            m_here[k]++;
            m_revp[k] = 0;
            return;
        end
        flip = far || ((m_revp[k] != 0 || rev) && m_pos[k] != 0 && m_pos[k] != N - 1
                       && tgt != 0 && tgt != N - 1);
        m_revp[k] = 0;
        if (flip) m_dir[k] = 1 - m_dir[k];
        m_prev[k] = m_pos[k];
        m_pos[k]  = m_dir[k] == 1 ? m_pos[k] + 1 : m_pos[k] - 1;
        m_here[k] = 0;
        m_end[k]  = (m_pos[k] == 0 || m_pos[k] == N - 1) ? 1 : 0;
    endtask
    function automatic int model_lamps(int k);
        return (1 << m_pos[k]) | ((TRAIL != 0 && m_prev[k] != m_pos[k]) ? (1 << m_prev[k]) : 0);
    endfunction
    initial forever begin
        @(posedge clk);
        for (int k = 0; k < NC; k++) model_tick(k);
        started = 1'b1;
    end
    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("m0_pos", int'(b0.o_pos), m_pos[0]);
            chk("m0_dir", int'(b0.o_dir), m_dir[0]);
            chk("m0_end", int'(b0.o_end), m_end[0]);
            chk("m0_lamps", int'(b0.o_lamps), model_lamps(0));
            chk("m1_pos", int'(b1.o_pos), m_pos[1]);
            chk("m1_dir", int'(b1.o_dir), m_dir[1]);
            chk("m1_end", int'(b1.o_end), m_end[1]);
            chk("m1_lamps", int'(b1.o_lamps), model_lamps(1));
        end
    end
    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask
    task automatic restart();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
    endtask
    initial begin
        rst = 1'b1;
        en  = 1'b1;
        cyc(3);
        rst = 1'b0;
        for (int s = 0; s < 16; s++) begin
            chk("seq0_pos", int'(b0.o_pos), exp_pos0[s]);
            chk("seq0_dir", int'(b0.o_dir), exp_dir0[s]);
            chk("seq0_end", int'(b0.o_end), exp_end0[s]);
            if (s < 12) chk("seq1_pos", int'(b1.o_pos), exp_pos1[s]);
            if (s == 0) chk("reset_lamps", int'(b0.o_lamps), 1);
            if (s == 3) chk("seq1_end_top", int'(b1.o_end), 1);
            if (s == 4) chk("lamps_pos2_up", int'(b0.o_lamps), TRAIL != 0 ? 6 : 4);
            if (s == 8) chk("seq1_end_bot", int'(b1.o_end), 1);
            cyc(1);
        end
        restart();
        cyc(2);
        chk("rev1_start", int'(b0.o_pos), 1);
        rev = 1'b1;
        cyc(1);
        rev = 1'b0;
        cyc(1);
        chk("rev1_pos", int'(b0.o_pos), 0);
        chk("rev1_dir", int'(b0.o_dir), 0);
        chk("rev1_end", int'(b0.o_end), 1);
        cyc(2);
        chk("rev1_bounce", int'(b0.o_pos), 1);
        chk("rev1_bounce_dir", int'(b0.o_dir), 1);
        restart();
        cyc(4);
        chk("rev2_start", int'(b0.o_pos), 2);
        rev = 1'b1;
        cyc(1);
        rev = 1'b0;
        cyc(1);
        chk("rev2_pos", int'(b0.o_pos), 3);
        chk("rev2_dir", int'(b0.o_dir), 1);
        cyc(2);
        chk("rev2_turn", int'(b0.o_pos), 2);
        cyc(2);
        chk("rev2_next", int'(b0.o_pos), 1);
        restart();
        cyc(5);
        chk("en_start", int'(b0.o_pos), 2);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("en_frozen", int'(b0.o_pos), 2);
        end
        en = 1'b1;
        cyc(1);
        chk("en_resume_wait", int'(b0.o_pos), 2);
        cyc(1);
        chk("en_resume_step", int'(b0.o_pos), 3);
        restart();
        cyc(6);
        chk("rst_mid_pre", int'(b0.o_pos), 3);
        rst = 1'b1;
        cyc(1);
        chk("rst_mid_pos", int'(b0.o_pos), 0);
        chk("rst_mid_dir", int'(b0.o_dir), 1);
        chk("rst_mid_lamps", int'(b0.o_lamps), 1);
        chk("rst_mid_end", int'(b0.o_end), 0);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rev = (i % 7 == 3);
            en  = (i % 11 != 5);
            cyc(1);
        end
        rev = 1'b0;
        en  = 1'b1;
        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/larson_sweep_ctrl.md
# larson_sweep_ctrl

Synchronous ping-pong sweep sequencer for the Larson scanner. It moves one lit lamp across an N-lamp bar and reverses direction at each end. It is the sequential counterpart to the discrete XOR direction-flip logic: the same "reverse at the end" decision, but registered and clocked. It sits between the board clock and the lamp driver outputs.

## Interface
- N_LAMPS, 8: lamp count, at least 2.
- DIV, 4: clock cycles per step, at least 1 (1 means one step every cycle).
- DWELL, 0: extra steps the lamp is held at each end, at least 0.
- i_clk  in  1  system clock; every state element updates on its rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_en  in  1  run enable; low freezes the sweep.
- i_rev  in  1  one-cycle pulse requesting a reversal at the next step.
- o_lamps  out  N_LAMPS  lamp drive, active-high.
- o_pos  out  $clog2(N_LAMPS)  current position.
- o_dir  out  1  direction: 1 = up (increasing position), 0 = down.
- o_end  out  1  one-cycle pulse when the position becomes 0 or N_LAMPS-1.

## Operation
- States: SWEEP_UP, DWELL_TOP, SWEEP_DOWN, DWELL_BOT.
- Reset values: state SWEEP_UP, pos 0, o_dir 1, o_lamps = 1, o_end 0, prescaler 0, rev_pending 0.
- Prescaler:
  - Counts 0..DIV-1 while i_en is high.
  - Emits an internal step on the cycle it holds DIV-1, then wraps to 0.
  - While i_en is low it is cleared to 0; state, pos and rev_pending hold.
- SWEEP_UP, on step:
  - If pos == N_LAMPS-1 and DWELL > 0: go to DWELL_TOP.
  - If pos == N_LAMPS-1 and DWELL == 0: go to SWEEP_DOWN with pos-1.
  - Otherwise pos+1.
- DWELL_TOP: counts DWELL steps, then on the next step goes to SWEEP_DOWN with pos-1.
- SWEEP_DOWN and DWELL_BOT mirror the two rules above: the end is pos == 0 and the move is pos+1.
- o_dir changes on the same edge that moves pos off an end.
- i_rev handling:
  - An i_rev pulse sets rev_pending.
  - At the next step in a SWEEP state, if pos is not at an end, direction flips and pos moves one position the new way. rev_pending then clears.
  - If that step is an end step, normal end handling wins and rev_pending is discarded.
  - In a DWELL state, i_rev is ignored and rev_pending stays clear.
- o_end is asserted on the edge where pos is loaded with 0 or N_LAMPS-1, and for that cycle only.
- Position arithmetic: unsigned, never below 0 and never above N_LAMPS-1.

## Timing
- All outputs are registered. o_lamps = 1 << o_pos, and both update on the same edge.
- First step lands on the DIV-th rising edge after reset release with i_en high.
- Each position is held DIV cycles; each end position is held (1+DWELL)·DIV cycles.
- Sequence for N_LAMPS=4, DWELL=0: 0,1,2,3,2,1,0,1,… The ends are never duplicated.
- i_rst in mid-sweep: every register reaches its reset value on that edge; i_rst has priority over every other input.
- If i_en falls on a step cycle, the step is not taken.

## Configuration
- Macro LARSON_TRAIL_EN.
  - Defined: adds register prev_pos, loaded with the old pos on every move. o_lamps = (1<<pos) | (1<<prev_pos) while prev_pos != pos; prev_pos resets to 0.
  - Undefined: o_lamps is single-hot, and prev_pos does not exist.

## Structure
- Package larson_pkg holds the state enum (sweep_state_t: SWEEP_UP, DWELL_TOP, SWEEP_DOWN, DWELL_BOT) and the localparam direction encodings DIR_UP=1, DIR_DOWN=0.
- Sub-module larson_prescaler (parameter DIV; ports i_clk, i_rst, i_en, o_step) produces the step pulse.
- The top level holds the FSM, the position register and the output decode.

## Test plan
- N_LAMPS=4, DIV=2, DWELL=0, i_en high after reset -> o_pos 0,1,2,3,2,1,0,1, each held 2 cycles; o_end pulses at 3 and 0; o_dir falls on the edge 3→2.
- N_LAMPS=4, DIV=1, DWELL=2 -> pos 3 held 3 cycles, then 2; pos 0 held 3 cycles, then 1.
- DIV=2, i_rev pulsed while pos=1 moving up -> next step gives pos 0, o_dir 0, o_end pulse.
- i_rev pulsed while pos=2 moving up (N=4) -> next step is the normal 2→3 move; the following step is 3→2; rev_pending is discarded.
- i_en dropped at pos=2 for 10 cycles -> outputs frozen; after re-enable the first step arrives DIV cycles later.
- i_rst asserted at pos=3 -> the next edge gives o_pos 0, o_dir 1, o_lamps 4'b0001, o_end 0; with LARSON_TRAIL_EN, o_lamps at pos=2 moving up is 4'b0110.
